// File: rtl/clock_monitor_driver.sv
// -----------------------------------------------------------------------------
// clock_monitor_driver
//   Drives a divided-down copy of the core clock onto a GPIO so off-chip logic
//   can count edges. Output is a registered square wave, half-period div+1
//   clocks. It runs either continuously while enabled or as a burst of
//   burst_len pulses per start. The output only ever goes low at the end of a
//   full high phase, so no runt pulses are produced.
//
//   Optional feature macro: CLKMON_PULSE_COUNT_EN
//     defined   : pulse_count counts mon_out rising edges (saturating) and
//                 clears on burst start / continuous-mode entry.
//     undefined : pulse_count is tied to 0.
//
// Ports
//   clock        in   core clock (single domain)
//   reset        in   asynchronous, active-high reset
//   enable       in   1 = output allowed; 0 = stop after the current high phase
//   burst_mode   in   0 = continuous, 1 = burst of burst_len pulses per start
//   start        in   one-cycle burst request (burst mode, IDLE only)
//   div          in   half-period minus one, resampled at each rising edge
//   burst_len    in   rising edges per burst; 0 completes immediately
//   mon_out      out  registered monitor pulse
//   busy         out  high while RUN or STOP
//   done         out  one-cycle pulse when a burst/run finishes
//   pulse_count  out  rising edges since last start/enable (feature macro)
// -----------------------------------------------------------------------------
module clock_monitor_driver #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             burst_mode,
    input  logic             start,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] burst_len,
    output logic             mon_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_count
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t           state_q, state_d;
    logic             mon_q, mon_d;
    logic             done_q, done_d;
    logic             mode_q, mode_d;
    logic [DIV_W-1:0] phase_q, phase_d;
    logic [DIV_W-1:0] div_l_q, div_l_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             phase_end;

    always_comb begin
        state_d   = state_q;
        mon_d     = mon_q;
        done_d    = 1'b0;
        mode_d    = mode_q;
        phase_d   = phase_q;
        div_l_d   = div_l_q;
        rem_d     = rem_q;
        phase_end = (phase_q == div_l_q);

        case (state_q)
            IDLE: begin
                mon_d   = 1'b0;
                phase_d = '0;
                if (enable && (!burst_mode || start)) begin
                    if (burst_mode && (burst_len == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        // Entry edge is itself the first rising edge, so the
                        // remaining-count already accounts for it.
                        state_d = RUN;
                        mode_d  = burst_mode;
                        div_l_d = div;
                        mon_d   = 1'b1;
                        rem_d   = burst_mode ? (burst_len - CNT_W'(1)) : '0;
                    end
                end
            end

            RUN: begin
                if (!enable && !mon_q) begin
                    // Low phase is not extended when enable drops.
                    state_d = IDLE;
                    done_d  = 1'b1;
                    phase_d = '0;
                end else begin
                    if (!enable) state_d = STOP;
                    if (phase_end) begin
                        phase_d = '0;
                        if (mon_q) begin
                            mon_d = 1'b0;
                            if (mode_q && (rem_q == '0)) state_d = STOP;
                        end else begin
                            mon_d   = 1'b1;
                            div_l_d = div;
                            if (mode_q && (rem_q != '0)) rem_d = rem_q - CNT_W'(1);
                        end
                    end else begin
                        phase_d = phase_q + DIV_W'(1);
                    end
                end
            end

            STOP: begin
                // Finish the high phase at full length, then one low cycle
                // before returning to IDLE with done.
                if (mon_q) begin
                    if (phase_end) begin
                        mon_d   = 1'b0;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + DIV_W'(1);
                    end
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    phase_d = '0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mon_q   <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= 1'b0;
            phase_q <= '0;
            div_l_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            mon_q   <= mon_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
            phase_q <= phase_d;
            div_l_q <= div_l_d;
            rem_q   <= rem_d;
        end
    end

    assign mon_out = mon_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

`ifdef CLKMON_PULSE_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_clr;

    always_comb begin
        cnt_clr = (state_q == IDLE) && enable && (!burst_mode || start);
        cnt_d   = cnt_clr ? '0 : cnt_q;
        // Clear and first rising edge share the entry cycle.
        if (mon_d && !mon_q && (cnt_d != '1)) cnt_d = cnt_d + CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign pulse_count = cnt_q;
`else
    assign pulse_count = '0;
`endif

endmodule

// File: tb/tb_clock_monitor_driver.sv
module tb_clock_monitor_driver;

    logic        clock, reset, enable, burst_mode, start;
    logic [7:0]  div;
    logic [15:0] burst_len;
    logic        mon_out, busy, done;
    logic [15:0] pulse_count;

    int n_cmp = 0;
    int n_bad = 0;
    int prev_cnt = 0;

    clock_monitor_driver #(.DIV_W(8), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .enable(enable), .burst_mode(burst_mode),
        .start(start), .div(div), .burst_len(burst_len), .mon_out(mon_out),
        .busy(busy), .done(done), .pulse_count(pulse_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit mode;
        int d;
        int n;
        int e_off;      // 0 = enable held until the burst finishes
        int exp_edges;
        int exp_done;   // cycle of done relative to the request cycle
    } vec_t;

    task automatic chk(input string nm, input int c, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, c, act, exp);
        end
    endtask

    function automatic int exp_cnt(input int c, input int s, input int p, input int l);
`ifdef CLKMON_PULSE_COUNT_EN
        int k;
        if (c < s) return prev_cnt;
        k = (c - s) / p + 1;
        return (k < l) ? k : l;
`else
        return 0;
`endif
    endfunction

    // Expected waveform from the pulse-train rules: rises at S + k*P for the
    // first L pulses, each high for d+1 cycles; done follows the last fall, or
    // lands on the enable-drop cycle if that drop happens during a low phase.
    task automatic run_scenario(input bit mode, input int d, input int n, input int e_off,
                                input bit noise, output int edges, output int done_at);
        int s, p, l, f, e, dn, nmax, ec;
        logic pm;
        s = 1;
        p = 2 * (d + 1);
        f = 0;
        if (mode && n == 0) begin
            l = 0; dn = s; e = s + 1;
        end else begin
            nmax = mode ? n : 1000000;
            e = (e_off == 0) ? 32'h3fff_ffff : s + e_off;
            l = 0;
            while (l < nmax && s + l * p < e) l++;
            f  = s + (l - 1) * p + d + 1;
            dn = (e > f && l < nmax) ? e : f + 1;
            if (l == nmax && e > f + 2) e = f + 2;
        end
        edges = 0; done_at = -1; pm = 1'b0;
        for (int c = 0; c <= dn + 2; c++) begin
            @(posedge clock); #1;
            chk("mon_out", c, mon_out, (c >= s && (c - s) / p < l && (c - s) % p <= d));
            chk("busy", c, busy, (c >= s && c < dn && !(mode && n == 0)));
            chk("done", c, done, (c == dn));
            ec = exp_cnt(c, s, p, l);
            chk("pulse_count", c, pulse_count, ec);
            if (mon_out && !pm) edges++;
            if (done && done_at < 0) done_at = c;
            pm = mon_out;
            enable = (c <= e - 2);
            div    = 8'(d);
            if (c == 0) begin
                burst_mode = mode; start = mode; burst_len = 16'(n);
            end else if (noise && c < dn) begin
                burst_mode = 1'($urandom); start = 1'($urandom);
                burst_len = 16'($urandom_range(0, 9));
            end else begin
                burst_mode = mode && (c < dn); start = 1'b0;
            end
        end
        enable = 1'b0; start = 1'b0; burst_mode = 1'b0;
`ifdef CLKMON_PULSE_COUNT_EN
        prev_cnt = l;
`endif
    endtask

    vec_t tbl[8];
    int   edges, dat, rises;
    logic pm;

    initial begin
        tbl[0] = '{1'b1, 0, 11, 0,   11, 23};
        tbl[1] = '{1'b0, 3, 0,  100, 13, 102};
        tbl[2] = '{1'b1, 2, 0,  0,   0,  1};
        tbl[3] = '{1'b1, 1, 1,  0,   1,  4};
        tbl[4] = '{1'b0, 2, 0,  4,   1,  5};
        tbl[5] = '{1'b0, 2, 0,  2,   1,  5};
        tbl[6] = '{1'b1, 3, 5,  9,   2,  14};
        tbl[7] = '{1'b1, 4, 3,  0,   3,  27};

        reset = 1'b1; enable = 1'b0; burst_mode = 1'b0; start = 1'b0;
        div = '0; burst_len = '0;
        #12;
        chk("rst_mon", 0, mon_out, 0);
        chk("rst_busy", 0, busy, 0);
        chk("rst_done", 0, done, 0);
        chk("rst_cnt", 0, pulse_count, 0);
        @(posedge clock); #1; reset = 1'b0;

        // enable low: nothing may happen regardless of other inputs
        rises = 0; pm = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clock); #1;
            if (mon_out && !pm) rises++;
            pm = mon_out;
            chk("idle_busy", c, busy, 0);
            chk("idle_done", c, done, 0);
            burst_mode = 1'($urandom); start = 1'($urandom);
            div = 8'($urandom); burst_len = 16'($urandom);
        end
        chk("idle_edges", 0, rises, 0);
        chk("idle_cnt", 0, pulse_count, 0);
        burst_mode = 1'b0; start = 1'b0;

        foreach (tbl[i]) begin
            run_scenario(tbl[i].mode, tbl[i].d, tbl[i].n, tbl[i].e_off, 1'b0, edges, dat);
            chk($sformatf("tbl%0d_edges", i), i, edges, tbl[i].exp_edges);
            chk($sformatf("tbl%0d_done", i), i, dat, tbl[i].exp_done);
        end

        // div 2 -> 5 during first high phase: second period uses 6-cycle phases
        for (int c = 0; c <= 27; c++) begin
            @(posedge clock); #1;
            chk("divchg_mon", c, mon_out,
                (c >= 1 && c <= 3) || (c >= 7 && c <= 12) || (c >= 19 && c <= 24));
            chk("divchg_done", c, done, (c == 26));
            enable = (c <= 24); burst_mode = 1'b0;
            div = (c >= 2) ? 8'd5 : 8'd2;
        end
        enable = 1'b0;
`ifdef CLKMON_PULSE_COUNT_EN
        prev_cnt = 3;
`endif

        // starts while busy are ignored, then a zero-length burst
        run_scenario(1'b1, 1, 4, 0, 1'b1, edges, dat);
        chk("busy_start_edges", 0, edges, 4);
        chk("busy_start_done", 0, dat, 16);
        run_scenario(1'b1, 2, 0, 0, 1'b1, edges, dat);
        chk("len0_edges", 0, edges, 0);
        chk("len0_done", 0, dat, 1);

        // async reset in the middle of a high phase
        for (int c = 0; c <= 3; c++) begin
            @(posedge clock); #1;
            enable = 1'b1; burst_mode = 1'b1; start = (c == 0);
            div = 8'd3; burst_len = 16'd5;
        end
        chk("pre_rst_mon", 3, mon_out, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_mon", 0, mon_out, 0);
        chk("arst_busy", 0, busy, 0);
        enable = 1'b0; start = 1'b0; burst_mode = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            chk("arst_done", c, done, 0);
        end
        reset = 1'b0;
        prev_cnt = 0;
        @(posedge clock); #1;
        chk("post_rst_done", 0, done, 0);
        run_scenario(1'b1, 0, 3, 0, 1'b0, edges, dat);
        chk("post_rst_edges", 0, edges, 3);
        chk("post_rst_done2", 0, dat, 7);

        // randomized scenarios against the pulse-train model
        for (int it = 0; it < 40; it++) begin
            bit m; int d, n, eo;
            m  = 1'($urandom);
            d  = $urandom_range(0, 4);
            n  = $urandom_range(0, 6);
            eo = m ? (($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0)
                   : $urandom_range(1, 50);
            run_scenario(m, d, n, eo, 1'b1, edges, dat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
